ahb_slv_regfile: RTL and testbench

AHB-Lite slave register block sitting directly downstream of the EVA bus-functional AHB master. It consumes the master's htrans/hwrite/haddr/hwdata transfers, returns hready/hresp/hrdata, and holds a small control/status register set. Its level interrupt output is the source monitored by the interrupt edge-capture stage. Wait-state insertion is configurable so the bench can stress master-side stall handling.

---
 rtl/ahb_slv_regfile.sv | 149 ++++++++++++++
 tb/tb_ahb_slv_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ahb_slv_regfile.sv
// AHB-Lite slave holding ID/SCRATCH/INT_RAW/INT_MASK/CNT registers, with
// configurable wait states, two-cycle ERROR response and a level interrupt.
module ahb_slv_regfile #(
   parameter logic [31:0] ID_VALUE = 32'hE0A0_0001,
   parameter int unsigned WAIT_CYC = 0,
   parameter int unsigned NUM_INT  = 8
) (
   input  logic               hclk,
   input  logic               rst_n,
   input  logic               hsel,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [31:0]        haddr,
   input  logic [2:0]         hsize,
   input  logic [31:0]        hwdata,
   input  logic               hready_in,
   output logic               hready_out,
   output logic [1:0]         hresp,
   output logic [31:0]        hrdata,
   input  logic [NUM_INT-1:0] intr_src,
   output logic               intr
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   typedef struct packed {
      logic       vld;
      logic       wr;
      logic [7:0] addr;
   } dphase_t;

   state_t             state_q, state_d;
   logic [3:0]         wcnt_q, wcnt_d;
   dphase_t            dp_q, dp_d;
   logic [31:0]        scratch_q, scratch_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [NUM_INT-1:0] raw_q, raw_d;
   logic [NUM_INT-1:0] mask_q, mask_d;
   logic [NUM_INT-1:0] src_dly_q, src_dly_d;
   logic               intr_q, intr_d;

   logic               accept, req_err, done;
   logic [NUM_INT-1:0] clr, rise;
   logic [31:0]        raw_rd, mask_rd, rd_data;
   logic               unused_ok;

   assign unused_ok = &{1'b0, haddr[31:8], htrans[0]};

   assign accept  = hsel & htrans[1] & hready_in & (state_q == S_IDLE);
   assign req_err = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | (haddr[7:0] > 8'h10);
   // A pending OKAY data phase completes once the FSM is back in IDLE.
   assign done    = (state_q == S_IDLE) & dp_q.vld;
   assign rise    = intr_src & ~src_dly_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      dp_d    = dp_q;
      case (state_q)
         S_IDLE: begin
            if (done) dp_d.vld = 1'b0;
            if (accept) begin
               dp_d.addr = haddr[7:0];
               dp_d.wr   = hwrite;
               if (req_err) begin
                  state_d = S_ERR1;
               end else begin
                  dp_d.vld = 1'b1;
                  if (WAIT_CYC > 0) begin
                     state_d = S_WAIT;
                     wcnt_d  = 4'(WAIT_CYC);
                  end
               end
            end
         end
         S_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) state_d = S_IDLE;
         end
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      raw_rd  = '0;
      mask_rd = '0;
      raw_rd[NUM_INT-1:0]  = raw_q;
      mask_rd[NUM_INT-1:0] = mask_q;
      case (dp_q.addr)
         8'h00:   rd_data = ID_VALUE;
         8'h04:   rd_data = scratch_q;
         8'h08:   rd_data = raw_rd;
         8'h0C:   rd_data = mask_rd;
         8'h10:   rd_data = cnt_q;
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      scratch_d = scratch_q;
      mask_d    = mask_q;
      clr       = '0;
      if (done & dp_q.wr) begin
         case (dp_q.addr)
            8'h04:   scratch_d = hwdata;
            8'h08:   clr       = hwdata[NUM_INT-1:0];
            8'h0C:   mask_d    = hwdata[NUM_INT-1:0];
            default: ;
         endcase
      end
      // Rising edge beats a simultaneous W1C on the same bit.
      raw_d     = (raw_q & ~clr) | rise;
      src_dly_d = intr_src;
      cnt_d     = done ? cnt_q + 32'd1 : cnt_q;
      intr_d    = |(raw_q & mask_q);
   end

   assign hready_out = (state_q != S_WAIT) & (state_q != S_ERR1);
   assign hresp      = ((state_q == S_ERR1) | (state_q == S_ERR2)) ? 2'b01 : 2'b00;
   assign hrdata     = (done & ~dp_q.wr) ? rd_data : 32'd0;
   assign intr       = intr_q;

   always_ff @(posedge hclk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         dp_q      <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         raw_q     <= '0;
         mask_q    <= '0;
         src_dly_q <= '0;
         intr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         dp_q      <= dp_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         raw_q     <= raw_d;
         mask_q    <= mask_d;
         src_dly_q <= src_dly_d;
         intr_q    <= intr_d;
      end
   end

endmodule

// File: tb/tb_ahb_slv_regfile.sv
// Directed bench: one slave with zero wait states, one with two, each acting
// as the only slave on its bus (hready_in tied to its own hready_out).
module tb_ahb_slv_regfile;

   localparam logic [31:0] ID = 32'hE0A0_0001;

   logic        hclk = 1'b0;
   logic        rst_n      [2];
   logic        hsel       [2];
   logic [1:0]  htrans     [2];
   logic        hwrite     [2];
   logic [31:0] haddr      [2];
   logic [2:0]  hsize      [2];
   logic [31:0] hwdata     [2];
   logic        hready_out [2];
   logic [1:0]  hresp      [2];
   logic [31:0] hrdata     [2];
   logic [7:0]  intr_src   [2];
   logic        intr       [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 hclk = ~hclk;

   ahb_slv_regfile #(.ID_VALUE(ID), .WAIT_CYC(0), .NUM_INT(8)) u_dut0 (
      .hclk(hclk), .rst_n(rst_n[0]), .hsel(hsel[0]), .htrans(htrans[0]),
      .hwrite(hwrite[0]), .haddr(haddr[0]), .hsize(hsize[0]), .hwdata(hwdata[0]),
      .hready_in(hready_out[0]), .hready_out(hready_out[0]), .hresp(hresp[0]),
      .hrdata(hrdata[0]), .intr_src(intr_src[0]), .intr(intr[0]));

   ahb_slv_regfile #(.ID_VALUE(ID), .WAIT_CYC(2), .NUM_INT(8)) u_dut2 (
      .hclk(hclk), .rst_n(rst_n[1]), .hsel(hsel[1]), .htrans(htrans[1]),
      .hwrite(hwrite[1]), .haddr(haddr[1]), .hsize(hsize[1]), .hwdata(hwdata[1]),
      .hready_in(hready_out[1]), .hready_out(hready_out[1]), .hresp(hresp[1]),
      .hrdata(hrdata[1]), .intr_src(intr_src[1]), .intr(intr[1]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   // One master transfer; returns at the negedge of the completion cycle.
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic [1:0] r1,
                       output logic [1:0] r2, output int stalls);
      @(negedge hclk);
      hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr;
      haddr[d] = {24'h0, addr}; hsize[d] = size;
      @(negedge hclk);
      hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wdata;
      r1 = hresp[d];
      stalls = 0;
      while (!hready_out[d] && stalls < 32) begin
         stalls++;
         @(negedge hclk);
      end
      if (stalls >= 32) chk("xfer_timeout", 32'(stalls), 32'd0);
      rdata = hrdata[d];
      r2 = hresp[d];
   endtask

   logic [31:0] rd;
   logic [1:0]  r1, r2;
   int          st;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; hsel[i] = 1'b0; htrans[i] = 2'b00; hwrite[i] = 1'b0;
         haddr[i] = '0; hsize[i] = 3'b010; hwdata[i] = '0; intr_src[i] = '0;
      end
      repeat (3) @(negedge hclk);
      chk("rst_hready", {31'd0, hready_out[0]}, 32'd1);
      chk("rst_hresp",  {30'd0, hresp[0]}, 32'd0);
      chk("rst_hrdata", hrdata[0], 32'd0);
      chk("rst_intr",   {31'd0, intr[0]}, 32'd0);
      chk("rst_hready_w2", {31'd0, hready_out[1]}, 32'd1);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // Zero wait states: ID then CNT (one completed transfer so far).
      xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, r1, r2, st);
      chk("id_data", rd, ID);
      chk("id_resp", {30'd0, r2}, 32'd0);
      chk("id_stalls", 32'(st), 32'd0);
      xfer(0, 1'b0, 8'h10, 3'b010, 32'h0, rd, r1, r2, st);
      chk("cnt_first", rd, 32'd1);

      // Pipelined write then read of SCRATCH.
      @(negedge hclk);
      hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h04;
      @(negedge hclk);
      hwdata[0] = 32'h1234_5678; hwrite[0] = 1'b0;
      chk("b2b_wr_ready", {31'd0, hready_out[0]}, 32'd1);
      @(negedge hclk);
      hsel[0] = 1'b0; htrans[0] = 2'b00;
      chk("b2b_rd_ready", {31'd0, hready_out[0]}, 32'd1);
      chk("b2b_rd_data", hrdata[0], 32'h1234_5678);

      // Error cases: out of range, unaligned, bad size.
      xfer(0, 1'b0, 8'h14, 3'b010, 32'h0, rd, r1, r2, st);
      chk("err14_r1", {30'd0, r1}, 32'd1);
      chk("err14_r2", {30'd0, r2}, 32'd1);
      chk("err14_stalls", 32'(st), 32'd1);
      chk("err14_data", rd, 32'd0);
      xfer(0, 1'b0, 8'h06, 3'b010, 32'h0, rd, r1, r2, st);
      chk("err06_r1", {30'd0, r1}, 32'd1);
      chk("err06_r2", {30'd0, r2}, 32'd1);
      xfer(0, 1'b1, 8'h04, 3'b000, 32'hBAD0_BAD0, rd, r1, r2, st);
      chk("errsz_r1", {30'd0, r1}, 32'd1);
      chk("errsz_stalls", 32'(st), 32'd1);
      xfer(0, 1'b0, 8'h04, 3'b010, 32'h0, rd, r1, r2, st);
      chk("scratch_kept", rd, 32'h1234_5678);
      xfer(0, 1'b0, 8'h10, 3'b010, 32'h0, rd, r1, r2, st);
      chk("cnt_no_err", rd, 32'd5);

      // Interrupt set, latency, W1C, and set-beats-clear.
      xfer(0, 1'b1, 8'h0C, 3'b010, 32'h1, rd, r1, r2, st);
      @(negedge hclk); intr_src[0] = 8'h01;
      @(negedge hclk); intr_src[0] = 8'h00;
      chk("intr_latency", {31'd0, intr[0]}, 32'd0);
      @(negedge hclk);
      chk("intr_set", {31'd0, intr[0]}, 32'd1);
      xfer(0, 1'b0, 8'h08, 3'b010, 32'h0, rd, r1, r2, st);
      chk("raw_set", rd, 32'h1);
      xfer(0, 1'b1, 8'h08, 3'b010, 32'h1, rd, r1, r2, st);
      repeat (2) @(negedge hclk);
      chk("intr_clr", {31'd0, intr[0]}, 32'd0);
      xfer(0, 1'b0, 8'h08, 3'b010, 32'h0, rd, r1, r2, st);
      chk("raw_clr", rd, 32'h0);
      @(negedge hclk); intr_src[0] = 8'h01;
      @(negedge hclk); intr_src[0] = 8'h00;
      @(negedge hclk);
      chk("intr_set2", {31'd0, intr[0]}, 32'd1);
      hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h08;
      @(negedge hclk);
      hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'h1; intr_src[0] = 8'h01;
      repeat (2) @(negedge hclk);
      chk("intr_race", {31'd0, intr[0]}, 32'd1);
      xfer(0, 1'b0, 8'h08, 3'b010, 32'h0, rd, r1, r2, st);
      chk("raw_race", rd, 32'h1);
      intr_src[0] = 8'h00;

      // Two wait states.
      xfer(1, 1'b1, 8'h04, 3'b010, 32'hDEAD_BEEF, rd, r1, r2, st);
      chk("w2_wr_stalls", 32'(st), 32'd2);
      chk("w2_wr_r1", {30'd0, r1}, 32'd0);
      xfer(1, 1'b0, 8'h04, 3'b010, 32'h0, rd, r1, r2, st);
      chk("w2_rd_stalls", 32'(st), 32'd2);
      chk("w2_rd_data", rd, 32'hDEAD_BEEF);
      xfer(1, 1'b0, 8'h14, 3'b010, 32'h0, rd, r1, r2, st);
      chk("w2_err_stalls", 32'(st), 32'd1);
      chk("w2_err_r1", {30'd0, r1}, 32'd1);

      // Reset during the wait of a write drops the write.
      @(negedge hclk);
      hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h04;
      @(negedge hclk);
      hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hA5A5_A5A5;
      chk("mid_wait", {31'd0, hready_out[1]}, 32'd0);
      rst_n[1] = 1'b0;
      @(negedge hclk);
      chk("mid_rst_ready", {31'd0, hready_out[1]}, 32'd1);
      chk("mid_rst_resp", {30'd0, hresp[1]}, 32'd0);
      rst_n[1] = 1'b1;
      xfer(1, 1'b0, 8'h04, 3'b010, 32'h0, rd, r1, r2, st);
      chk("mid_rst_scratch", rd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
